fun_root_mul: RTL and testbench

- Parametrised successor of the fixed 8-bit a*cbrt(b) datapath block.
- Computes result = a * floor(root_k(b)), with k = 2 (square root) or k = 3 (cube root) selected per operation.
- Iterative multi-cycle engine with a start/busy/done handshake. Contains its own controller, root engine and shift-add multiplier, and may share one internal adder.
- Used wherever the datapath needs a scaled root of an operand of any width.

---
 rtl/fun_root_mul_if.sv | 24 ++
 rtl/fun_root_mul.sv | 171 +++++++++++++++++
 tb/tb_fun_root_mul.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fun_root_mul_if.sv
// Request/response bundle for fun_root_mul: operand request in, busy/done/result back.
// The master side drives start and the operands. The slave (the engine) returns status and the product.
interface fun_root_mul_if #(
    parameter int W  = 8,
    parameter int RB = (W + 1) / 2
);
    logic            start;
    logic            mode;
    logic [W-1:0]    a_i;
    logic [W-1:0]    b_i;
    logic            busy;
    logic            done;
    logic [W+RB-1:0] result;

    modport master (
        output start, mode, a_i, b_i,
        input  busy, done, result
    );

    modport slave (
        input  start, mode, a_i, b_i,
        output busy, done, result
    );
endinterface

// File: rtl/fun_root_mul.sv
// result = a * floor(root_k(b)), k = 2 or 3, using a bit-serial root search and a shift-add multiply.
// Every step uses one shared adder, and the latency depends only on W and mode.
module fun_root_mul #(
    parameter int W  = 8,
    parameter int RB = (W + 1) / 2
) (
    input  logic          clk,
    input  logic          rst,
    fun_root_mul_if.slave bus
);
    localparam int PW = 3 * RB;
    localparam int RW = W + RB;
    localparam int CW = $clog2(RB);

    typedef enum logic [1:0] {S_IDLE, S_ROOT, S_MUL, S_DONE} state_t;
    typedef enum logic [1:0] {P_SQ, P_CU, P_CMP} phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   bit_q, bit_d;
    logic [CW-1:0]   step_q, step_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            mode_q, mode_d;
    logic [RB-1:0]   root_q, root_d;
    logic [PW-1:0]   sq_q, sq_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [RW-1:0]   result_q, result_d;

    logic [RB-1:0]   trial;
    logic [PW-1:0]   add_y;
    logic [PW-1:0]   sum;
    logic            last_step;

    assign trial     = root_q | (RB'(1) << bit_q);
    assign last_step = (step_q == CW'(RB - 1));

    // Operand select for the single adder. acc_q is always the other input:
    // it accumulates trial^2, then trial^3, and finally the product.
    always_comb begin
        add_y = '0;
        case (state_q)
            S_ROOT: begin
                if (phase_q == P_SQ && trial[step_q])
                    add_y = PW'(trial) << step_q;
                else if (phase_q == P_CU && trial[step_q])
                    add_y = sq_q << step_q;
            end
            S_MUL: begin
                if (root_q[step_q])
                    add_y = PW'(a_q) << step_q;
            end
            default: add_y = '0;
        endcase
    end

    assign sum = acc_q + add_y;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        step_d   = step_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        root_d   = root_q;
        sq_d     = sq_q;
        acc_d    = acc_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ROOT;
                    phase_d = P_SQ;
                    bit_d   = CW'(RB - 1);
                    step_d  = '0;
                    a_d     = bus.a_i;
                    b_d     = bus.b_i;
                    mode_d  = bus.mode;
                    root_d  = '0;
                    sq_d    = '0;
                    acc_d   = '0;
                end
            end
            S_ROOT: begin
                case (phase_q)
                    P_SQ: begin
                        acc_d  = sum;
                        step_d = step_q + 1'b1;
                        if (last_step) begin
                            step_d = '0;
                            if (mode_q) begin
                                sq_d    = sum;
                                acc_d   = '0;
                                phase_d = P_CU;
                            end else begin
                                phase_d = P_CMP;
                            end
                        end
                    end
                    P_CU: begin
                        acc_d  = sum;
                        step_d = step_q + 1'b1;
                        if (last_step) begin
                            step_d  = '0;
                            phase_d = P_CMP;
                        end
                    end
                    P_CMP: begin
                        if (acc_q <= PW'(b_q))
                            root_d = trial;
                        acc_d   = '0;
                        phase_d = P_SQ;
                        if (bit_q == '0)
                            state_d = S_MUL;
                        else
                            bit_d = bit_q - 1'b1;
                    end
                    default: phase_d = P_SQ;
                endcase
            end
            S_MUL: begin
                acc_d  = sum;
                step_d = step_q + 1'b1;
                if (last_step) begin
                    step_d   = '0;
                    result_d = sum[RW-1:0];
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= P_SQ;
            bit_q    <= '0;
            step_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            root_q   <= '0;
            sq_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            step_q   <= step_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            root_q   <= root_d;
            sq_q     <= sq_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_fun_root_mul.sv
// Scoreboard bench for fun_root_mul at W=8 and W=16. Stimulus queues the expected results.
// Per-DUT monitors check each done pulse for result, latency constancy and latency bound.
module tb_fun_root_mul;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fun_root_mul_if #(.W(8))  bus8  ();
    fun_root_mul_if #(.W(16)) bus16 ();

    fun_root_mul #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    fun_root_mul #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    typedef struct {
        longint exp;
        logic   m;
        int     acc;
        int     id;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   nid     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic longint iroot(input longint b, input bit cube);
        longint r = 0;
        while (((r + 1) * (r + 1) * (cube ? (r + 1) : 64'd1)) <= b) r++;
        return r;
    endfunction

    // ---------------- monitors ----------------
    initial begin
        int   lref[2];
        bit   dpend;
        exp_t e;
        int   lat;
        lref[0] = -1; lref[1] = -1; dpend = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dpend) begin
                    chk("done_width8", longint'(bus8.done), 0);
                    dpend = 0;
                end else if (bus8.done) begin
                    chk("queued8", longint'(q8.size() > 0), 1);
                    if (q8.size() > 0) begin
                        e   = q8.pop_front();
                        lat = cyc - e.acc;
                        $display("dut8  op%0d mode=%0d result=%0d exp=%0d latency=%0d",
                                 e.id, e.m, bus8.result, e.exp, lat);
                        chk("result8", longint'(bus8.result), e.exp);
                        chk("lat_bound8", longint'(lat <= 4 * 8 * 4 + 4), 1);
                        if (lref[e.m] < 0) lref[e.m] = lat;
                        else chk("lat_const8", lat, lref[e.m]);
                    end
                    dpend = 1;
                end
            end
        end
    end

    initial begin
        int   lref[2];
        bit   dpend;
        exp_t e;
        int   lat;
        lref[0] = -1; lref[1] = -1; dpend = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dpend) begin
                    chk("done_width16", longint'(bus16.done), 0);
                    dpend = 0;
                end else if (bus16.done) begin
                    chk("queued16", longint'(q16.size() > 0), 1);
                    if (q16.size() > 0) begin
                        e   = q16.pop_front();
                        lat = cyc - e.acc;
                        $display("dut16 op%0d mode=%0d result=%0d exp=%0d latency=%0d",
                                 e.id, e.m, bus16.result, e.exp, lat);
                        chk("result16", longint'(bus16.result), e.exp);
                        chk("lat_bound16", longint'(lat <= 4 * 16 * 8 + 4), 1);
                        if (lref[e.m] < 0) lref[e.m] = lat;
                        else chk("lat_const16", lat, lref[e.m]);
                    end
                    dpend = 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle8();
        int g = 0;
        while (bus8.busy && g < 1000) begin @(negedge clk); g++; end
        if (bus8.busy) chk("idle_timeout8", longint'(bus8.busy), 0);
    endtask

    task automatic wait_idle16();
        int g = 0;
        while (bus16.busy && g < 1000) begin @(negedge clk); g++; end
        if (bus16.busy) chk("idle_timeout16", longint'(bus16.busy), 0);
    endtask

    task automatic run8(input logic m, input logic [7:0] a, input logic [7:0] b, input longint exp);
        wait_idle8();
        bus8.start = 1'b1; bus8.mode = m; bus8.a_i = a; bus8.b_i = b;
        q8.push_back('{exp: exp, m: m, acc: cyc + 1, id: nid});
        nid++;
        @(negedge clk);
        bus8.start = 1'b0; bus8.mode = ~m; bus8.a_i = ~a; bus8.b_i = ~b;
    endtask

    task automatic run16(input logic m, input logic [15:0] a, input logic [15:0] b, input longint exp);
        wait_idle16();
        bus16.start = 1'b1; bus16.mode = m; bus16.a_i = a; bus16.b_i = b;
        q16.push_back('{exp: exp, m: m, acc: cyc + 1, id: nid});
        nid++;
        @(negedge clk);
        bus16.start = 1'b0; bus16.mode = ~m; bus16.a_i = ~a; bus16.b_i = ~b;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          g;
        logic [7:0]  ra, rb;
        rst = 1'b1;
        bus8.start  = 1'b0; bus8.mode  = 1'b0; bus8.a_i  = '0; bus8.b_i  = '0;
        bus16.start = 1'b0; bus16.mode = 1'b0; bus16.a_i = '0; bus16.b_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy8",   longint'(bus8.busy),    0);
        chk("rst_done8",   longint'(bus8.done),    0);
        chk("rst_result8", longint'(bus8.result),  0);
        chk("rst_busy16",  longint'(bus16.busy),   0);
        rst = 1'b0;
        @(negedge clk);

        // directed W=8 vectors
        run8(1'b1, 8'd10,  8'd27,  30);
        run8(1'b1, 8'd255, 8'd255, 1530);
        run8(1'b0, 8'd255, 8'd255, 3825);
        run8(1'b0, 8'd7,   8'd0,   0);
        run8(1'b0, 8'd0,   8'd200, 0);
        run8(1'b1, 8'd9,   8'd1,   9);

        // handshake: start held high, inputs toggling through busy
        wait_idle8();
        bus8.start = 1'b1; bus8.mode = 1'b1; bus8.a_i = 8'd10; bus8.b_i = 8'd27;
        q8.push_back('{exp: 30, m: 1'b1, acc: cyc + 1, id: nid});
        nid++;
        @(negedge clk);
        chk("busy_after_accept", longint'(bus8.busy), 1);
        g = 0;
        while (!bus8.done && g < 500) begin
            bus8.a_i  = 8'($urandom);
            bus8.b_i  = 8'($urandom);
            bus8.mode = ~bus8.mode;
            @(negedge clk);
            g++;
        end
        chk("hs_done_seen", longint'(bus8.done), 1);
        bus8.mode = 1'b0; bus8.a_i = 8'd5; bus8.b_i = 8'd100;
        q8.push_back('{exp: 50, m: 1'b0, acc: cyc + 2, id: nid});
        nid++;
        @(negedge clk);
        chk("hs_idle_gap", longint'(bus8.busy), 0);
        @(negedge clk);
        chk("hs_reaccept", longint'(bus8.busy), 1);
        bus8.start = 1'b0;
        wait_idle8();

        // asynchronous reset in the middle of an operation
        run8(1'b1, 8'd200, 8'd100, 800);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy",   longint'(bus8.busy),   0);
        chk("midrst_done",   longint'(bus8.done),   0);
        chk("midrst_result", longint'(bus8.result), 0);
        q8.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_idle", longint'(bus8.busy), 0);
        repeat (50) @(negedge clk);
        run8(1'b1, 8'd3, 8'd64, 12);

        // random operands, both modes, checked against a linear-search root
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 50; i++) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                run8(m[0], ra, rb, longint'(ra) * iroot(longint'(rb), m[0]));
            end
        end

        // W=16 instance
        run16(1'b0, 16'd65535, 16'd65535, 16711425);
        run16(1'b1, 16'd65535, 16'd65535, 2621400);
        run16(1'b1, 16'd1,     16'd64000, 40);
        run16(1'b1, 16'd1,     16'd63999, 39);
        run16(1'b0, 16'd1,     16'd64000, 252);

        g = 0;
        while ((q8.size() + q16.size()) > 0 && g < 2000) begin @(negedge clk); g++; end
        chk("drain", longint'(q8.size() + q16.size()), 0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
